// File: rtl/bcd_serial_converter.sv
// Serial binary-to-BCD converter (shift-and-add-3), one operand bit per clock.
// Optional macro BCD_SIGNED_EN: treat data as two's complement and report sign on neg.
module bcd_serial_converter #(
  parameter int DATA_W = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     data,
  output logic                  busy,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  opnd_q;
  logic [BCD_W-1:0]   dig_q;
  logic [BCD_W-1:0]   dig_adj;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_acc_q;
  logic               neg_acc_q;
  logic [DATA_W-1:0]  mag;
  logic               sign;

`ifdef BCD_SIGNED_EN
  // Negating the most negative value wraps to itself, which read unsigned is exactly 2^(DATA_W-1).
  assign sign = data[DATA_W-1];
  assign mag  = sign ? -data : data;
`else
  assign sign = 1'b0;
  assign mag  = data;
`endif

  assign busy = (state_q != IDLE);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    dig_adj = dig_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_q[4*i +: 4] >= 4'd5) dig_adj[4*i +: 4] = dig_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      opnd_q    <= '0;
      dig_q     <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      neg_acc_q <= 1'b0;
      valid     <= 1'b0;
      bcd       <= '0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state_q <= state_d;
      valid   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            opnd_q    <= mag;
            neg_acc_q <= sign;
            dig_q     <= '0;
            ovf_acc_q <= 1'b0;
            cnt_q     <= CNT_W'(DATA_W);
          end
        end
        SHIFT: begin
          // A 1 leaving the top digit means the value needs more than DIGITS digits.
          {dig_q, opnd_q} <= {dig_adj[BCD_W-2:0], opnd_q, 1'b0};
          ovf_acc_q       <= ovf_acc_q | dig_adj[BCD_W-1];
          cnt_q           <= cnt_q - CNT_W'(1);
        end
        DONE: begin
          valid <= 1'b1;
          bcd   <= ovf_acc_q ? {DIGITS{4'h9}} : dig_q;
          neg   <= neg_acc_q;
          ovf   <= ovf_acc_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_converter.sv
// Directed bench for bcd_serial_converter: a 5-digit and a 4-digit instance share stimulus.
module tb_bcd_serial_converter;

  logic        clk, rst, start;
  logic [15:0] data;
  logic        busy5, valid5, neg5, ovf5;
  logic [19:0] bcd5;
  logic        busy4, valid4, neg4, ovf4;
  logic [15:0] bcd4;
  int          vectors = 0;
  int          miscompares = 0;

  bcd_serial_converter #(.DATA_W(16), .DIGITS(5)) u_dut5 (
    .clk(clk), .rst(rst), .start(start), .data(data),
    .busy(busy5), .valid(valid5), .bcd(bcd5), .neg(neg5), .ovf(ovf5)
  );

  bcd_serial_converter #(.DATA_W(16), .DIGITS(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .data(data),
    .busy(busy4), .valid(valid4), .bcd(bcd4), .neg(neg4), .ovf(ovf4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits for valid5 after the accepting edge; returns edges elapsed (40 = timed out).
  task automatic wait_valid(output int n);
    n = 0;
    while (!valid5 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 16 && !valid5) check("busy_edge16", busy5, 1'b1);
    end
  endtask

  task automatic convert(input string tag, input logic [15:0] d,
                         input logic [19:0] e5, input logic o5,
                         input logic [15:0] e4, input logic o4, input logic eneg);
    int n;
    @(negedge clk);
    start = 1'b1;
    data  = d;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_busy0"}, busy5, 1'b1);
    wait_valid(n);
    check({tag, "_latency"}, n, 17);
    check({tag, "_busy_in_valid"}, busy5, 1'b0);
    check({tag, "_valid4"}, valid4, 1'b1);
    check({tag, "_bcd5"}, bcd5, e5);
    check({tag, "_ovf5"}, ovf5, o5);
    check({tag, "_neg"}, neg5, eneg);
    check({tag, "_bcd4"}, bcd4, e4);
    check({tag, "_ovf4"}, ovf4, o4);
    @(posedge clk);
    #1;
    check({tag, "_valid_1cyc"}, valid5, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_hold"}, {ovf5, bcd5}, {o5, e5});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, pulses;
    clk = 1'b0; rst = 1'b0; start = 1'b0; data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {busy5, valid5, bcd5, neg5, ovf5}, '0);
    @(negedge clk);
    rst = 1'b1;

    // tag, data, bcd(5 digits), ovf5, bcd(4 digits), ovf4, neg
    convert("d360",   16'd360,   20'h00360, 1'b0, 16'h0360, 1'b0, 1'b0);
    convert("zero",   16'd0,     20'h00000, 1'b0, 16'h0000, 1'b0, 1'b0);
    convert("d9999",  16'd9999,  20'h09999, 1'b0, 16'h9999, 1'b0, 1'b0);
    convert("d1",     16'd1,     20'h00001, 1'b0, 16'h0001, 1'b0, 1'b0);
`ifdef BCD_SIGNED_EN
    convert("m360",   16'hFE98,  20'h00360, 1'b0, 16'h0360, 1'b0, 1'b1);
    convert("min",    16'h8000,  20'h32768, 1'b0, 16'h9999, 1'b1, 1'b1);
    convert("max",    16'h7FFF,  20'h32767, 1'b0, 16'h9999, 1'b1, 1'b0);
    convert("m1",     16'hFFFF,  20'h00001, 1'b0, 16'h0001, 1'b0, 1'b1);
`else
    convert("d10000", 16'd10000, 20'h10000, 1'b0, 16'h9999, 1'b1, 1'b0);
    convert("h8000",  16'h8000,  20'h32768, 1'b0, 16'h9999, 1'b1, 1'b0);
    convert("d65535", 16'hFFFF,  20'h65535, 1'b0, 16'h9999, 1'b1, 1'b0);
`endif

    // start while busy is ignored
    @(negedge clk);
    start = 1'b1; data = 16'd360;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; data = 16'd1234;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 5;
    while (!valid5 && n < 40) begin @(posedge clk); #1; n++; end
    check("ignore_latency", n, 17);
    check("ignore_bcd", bcd5, 20'h00360);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; if (valid5) pulses++; end
    check("ignore_no_second_valid", pulses, 0);

    // start held high: back-to-back conversions
    @(negedge clk);
    start = 1'b1; data = 16'd360;
    @(posedge clk);
    #1;
    data = 16'd4321;
    wait_valid(n);
    check("b2b_first_latency", n, 17);
    check("b2b_first_bcd", bcd5, 20'h00360);
    @(posedge clk);
    #1;
    data = 16'd777;
    n = 1;
    while (!valid5 && n < 40) begin @(posedge clk); #1; n++; end
    start = 1'b0;
    check("b2b_period", n, 18);
    check("b2b_second_bcd", bcd5, 20'h04321);
    repeat (2) @(posedge clk);

    // reset mid-conversion aborts without a result
    convert("pre_abort", 16'd9876, 20'h09876, 1'b0, 16'h9876, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1; data = 16'd5555;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_outputs5", {busy5, valid5, bcd5, neg5, ovf5}, '0);
    check("abort_outputs4", {busy4, valid4, bcd4, neg4, ovf4}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin @(posedge clk); #1; if (valid5) pulses++; end
    check("abort_no_valid", pulses, 0);
    convert("post_abort", 16'd2024, 20'h02024, 1'b0, 16'h2024, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
